// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control blocks: FSM state encoding and
// legal parameter ranges.
package fifo_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_e;

    localparam int unsigned NUM_REQ_MIN   = 2;
    localparam int unsigned NUM_REQ_MAX   = 16;
    localparam int unsigned MAX_BURST_MIN = 1;
    localparam int unsigned MAX_BURST_MAX = 255;
    localparam int unsigned RD_LAT_MIN    = 1;
    localparam int unsigned RD_LAT_MAX    = 4;

    function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward from
// start+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Offset 1..NUM_REQ so the start index itself is checked last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(start) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ requesters, with
// a per-grant burst limit and a read-data-valid strobe aligned to RD_LAT.
module fifo_read_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic               i_clk,
    input  logic               i_rest,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_empty,
    output logic               o_ren,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [NUM_REQ-1:0] o_rvalid,
    output logic               o_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    if (!in_range(NUM_REQ, NUM_REQ_MIN, NUM_REQ_MAX) ||
        !in_range(MAX_BURST, MAX_BURST_MIN, MAX_BURST_MAX) ||
        !in_range(RD_LAT, RD_LAT_MIN, RD_LAT_MAX)) begin : g_param_err
        $error("fifo_read_arbiter: parameter out of legal range");
    end

    rd_state_e        state_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [IDX_W-1:0] last_idx_q;
    logic [CNT_W-1:0] burst_cnt_q;

    logic [RD_LAT-1:0] rv_valid_q;
    logic [IDX_W-1:0]  rv_idx_q [RD_LAT];

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             burst_done;
    logic             read_exit;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req  (i_req),
        .start(last_idx_q),
        .found(pick_found),
        .idx  (pick_idx)
    );

    assign o_ren      = (state_q == ST_READ) && i_req[gnt_idx_q] && !i_empty;
    assign burst_done = o_ren && (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    // An empty FIFO releases the grant rather than stalling the holder.
    assign read_exit  = !i_req[gnt_idx_q] || i_empty || burst_done;
    assign o_busy     = (state_q == ST_READ);

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            state_q     <= ST_IDLE;
            gnt_idx_q   <= '0;
            last_idx_q  <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found && !i_empty) begin
                        gnt_idx_q   <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (o_ren) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                    if (read_exit) begin
                        state_q    <= ST_IDLE;
                        last_idx_q <= gnt_idx_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            rv_valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                rv_idx_q[i] <= '0;
            end
        end else begin
            rv_valid_q[0] <= o_ren;
            rv_idx_q[0]   <= gnt_idx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_valid_q[i] <= rv_valid_q[i-1];
                rv_idx_q[i]   <= rv_idx_q[i-1];
            end
        end
    end

    always_comb begin
        o_gnt    = '0;
        o_rvalid = '0;
        if (state_q == ST_READ) begin
            o_gnt[gnt_idx_q] = 1'b1;
        end
        if (rv_valid_q[RD_LAT-1]) begin
            o_rvalid[rv_idx_q[RD_LAT-1]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: vector table with an rvalid
// scoreboard on the default configuration, plus hand-written corner sequences.
module tb_fifo_read_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req0, req1;
    logic [1:0] req2;
    logic       empty0, empty1, empty2;
    logic       ren0, ren1, ren2;
    logic [3:0] gnt0, gnt1, rvalid0, rvalid1;
    logic [1:0] gnt2, rvalid2;
    logic       busy0, busy1, busy2;

    fifo_read_arbiter #(.NUM_REQ(4), .MAX_BURST(8), .RD_LAT(1)) dut0 (
        .i_clk(clk), .i_rest(rst), .i_req(req0), .i_empty(empty0),
        .o_ren(ren0), .o_gnt(gnt0), .o_rvalid(rvalid0), .o_busy(busy0)
    );

    fifo_read_arbiter #(.NUM_REQ(4), .MAX_BURST(8), .RD_LAT(3)) dut1 (
        .i_clk(clk), .i_rest(rst), .i_req(req1), .i_empty(empty1),
        .o_ren(ren1), .o_gnt(gnt1), .o_rvalid(rvalid1), .o_busy(busy1)
    );

    fifo_read_arbiter #(.NUM_REQ(2), .MAX_BURST(1), .RD_LAT(1)) dut2 (
        .i_clk(clk), .i_rest(rst), .i_req(req2), .i_empty(empty2),
        .o_ren(ren2), .o_gnt(gnt2), .o_rvalid(rvalid2), .o_busy(busy2)
    );

    typedef struct {
        bit         rst_first;
        logic [3:0] req;
        logic       empty;
        logic       ren;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        int         due;
        logic [3:0] mask;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic [3:0] q, input logic e, input logic rn,
                       input logic [3:0] g);
        vec_t v;
        v.rst_first = r;
        v.req       = q;
        v.empty     = e;
        v.ren       = rn;
        v.gnt       = g;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req0   = '0;
        req1   = '0;
        req2   = '0;
        empty0 = 1'b0;
        empty1 = 1'b0;
        empty2 = 1'b0;
        #1;
        chk("reset ren", 0, 32'(ren0), 0);
        chk("reset gnt", 0, 32'(gnt0), 0);
        chk("reset rvalid", 0, 32'(rvalid0), 0);
        chk("reset busy", 0, 32'(busy0), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle 0: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [3:0] exp_rv;
        logic [3:0] oh;
        logic [1:0] g6;
        logic [1:0] prev_g6;
        logic       prev_r6;

        rst    = 1'b1;
        req0   = '0;
        req1   = '0;
        req2   = '0;
        empty0 = 1'b0;
        empty1 = 1'b0;
        empty2 = 1'b0;

        // Single requester: 8-read bursts separated by one arbitration bubble.
        add(1, 4'b0001, 0, 0, 4'b0000);
        for (int c = 1; c < 20; c++) begin
            if (c == 9 || c == 18) add(0, 4'b0001, 0, 0, 4'b0000);
            else                   add(0, 4'b0001, 0, 1, 4'b0001);
        end
        // All requesting: grants rotate 0,1,2,3,0.
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            add(g == 0, 4'b1111, 0, 0, 4'b0000);
            for (int k = 0; k < 8; k++) add(0, 4'b1111, 0, 1, oh);
        end
        // Requester 2 drained by empty after 3 reads; refill goes to requester 3.
        add(1, 4'b1100, 0, 0, 4'b0000);
        for (int k = 0; k < 3; k++) add(0, 4'b1100, 0, 1, 4'b0100);
        add(0, 4'b1100, 1, 0, 4'b0100);
        add(0, 4'b1100, 1, 0, 4'b0000);
        add(0, 4'b1100, 1, 0, 4'b0000);
        add(0, 4'b1100, 0, 0, 4'b0000);
        add(0, 4'b1100, 0, 1, 4'b1000);
        add(0, 4'b1100, 0, 1, 4'b1000);
        // Requester 1 drops after 2 reads; next arbitration starts after 1.
        add(1, 4'b0010, 0, 0, 4'b0000);
        add(0, 4'b0010, 0, 1, 4'b0010);
        add(0, 4'b0010, 0, 1, 4'b0010);
        add(0, 4'b0000, 0, 0, 4'b0010);
        add(0, 4'b0110, 0, 0, 4'b0000);
        add(0, 4'b0110, 0, 1, 4'b0100);
        add(0, 4'b0000, 0, 0, 4'b0100);

        cyc = 0;
        foreach (vecs[n]) begin
            if (vecs[n].rst_first) begin
                do_reset();
                cyc = 0;
            end
            @(negedge clk);
            req0   = vecs[n].req;
            empty0 = vecs[n].empty;
            #1;
            exp_rv = '0;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_rv = exp_rv | sb.pop_front().mask;
            end
            chk("ren", cyc, 32'(ren0), 32'(vecs[n].ren));
            chk("gnt", cyc, 32'(gnt0), 32'(vecs[n].gnt));
            chk("busy", cyc, 32'(busy0), 32'(|vecs[n].gnt));
            chk("rvalid", cyc, 32'(rvalid0), 32'(exp_rv));
            if (vecs[n].ren) sb.push_back('{due: cyc + 1, mask: vecs[n].gnt});
            cyc++;
        end

        // RD_LAT=3: async reset mid-burst kills in-flight strobes.
        do_reset();
        @(negedge clk); req1 = 4'b0001; #1;
        chk("lat3 idle ren", 0, 32'(ren1), 0);
        @(negedge clk); #1;
        chk("lat3 ren", 1, 32'(ren1), 1);
        chk("lat3 gnt", 1, 32'(gnt1), 32'h1);
        @(negedge clk); #1;
        chk("lat3 ren", 2, 32'(ren1), 1);
        @(negedge clk); #1;
        chk("lat3 busy", 3, 32'(busy1), 1);
        #2 rst = 1'b1;
        #1;
        chk("async ren", 3, 32'(ren1), 0);
        chk("async gnt", 3, 32'(gnt1), 0);
        chk("async busy", 3, 32'(busy1), 0);
        chk("async rvalid", 3, 32'(rvalid1), 0);
        @(negedge clk);
        req1 = '0;
        rst  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("post-reset rvalid", c, 32'(rvalid1), 0);
        end
        @(negedge clk); req1 = 4'b1001; #1;
        chk("lat3 rearb ren", 0, 32'(ren1), 0);
        @(negedge clk); #1;
        chk("lat3 rearb gnt", 1, 32'(gnt1), 32'h1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("lat3 early rvalid", 3, 32'(rvalid1), 0);
        @(negedge clk); #1;
        chk("lat3 rvalid", 4, 32'(rvalid1), 32'h1);

        // MAX_BURST=1, two requesters: one read per grant, alternating.
        do_reset();
        prev_r6 = 1'b0;
        prev_g6 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); req2 = 2'b11; #1;
            g6 = (c % 2 == 1) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("mb1 ren", c, 32'(ren2), 32'(c % 2));
            chk("mb1 gnt", c, 32'(gnt2), 32'(g6));
            chk("mb1 rvalid", c, 32'(rvalid2), prev_r6 ? 32'(prev_g6) : 32'h0);
            prev_r6 = (c % 2 == 1);
            prev_g6 = g6;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Shares the single read port of one synchronous FIFO among `NUM_REQ` requesters using round-robin arbitration with a per-grant burst limit. It gates the FIFO read enable so a read is never issued while the FIFO is empty. It returns a one-hot read-data-valid strobe aligned to the FIFO read latency. It sits between the FIFO and its downstream consumers, in place of per-consumer read-enable control.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `MAX_BURST`, 8: maximum reads per grant before forced re-arbitration; legal range 1..255.
- `RD_LAT`, 1: FIFO read latency in cycles, from `o_ren` to data on the FIFO output; legal range 1..4.

- `i_clk`  in  1: clock; all state is updated on the rising edge.
- `i_rest`  in  1: reset; asynchronous, active-high.
- `i_req`  in  NUM_REQ: per-requester read request; level-sensitive.
- `i_empty`  in  1: FIFO empty flag, synchronous to `i_clk`.
- `o_ren`  out  1: FIFO read enable.
- `o_gnt`  out  NUM_REQ: one-hot current grant; all zero when no grant is held.
- `o_rvalid`  out  NUM_REQ: one-hot strobe marking that FIFO data on the shared bus belongs to that requester.
- `o_busy`  out  1: high while a grant is held.

## Operation
- States: IDLE and READ, with encoding 0 and 1.
- Registered state:
  - `gnt_idx`, `$clog2(NUM_REQ)` bits.
  - `last_idx`, the round-robin pointer.
  - `burst_cnt`, `$clog2(MAX_BURST+1)` bits.
  - the rvalid pipeline, `RD_LAT` stages of {valid, index}.
- IDLE behaviour:
  - If `|i_req` and `!i_empty`, pick the first asserted requester scanning from `last_idx+1` upward, wrapping modulo `NUM_REQ`.
  - Load `gnt_idx`, clear `burst_cnt`, go to READ.
  - Otherwise stay in IDLE.
  - `o_ren` is 0 in IDLE.
- READ behaviour:
  - `o_ren = i_req[gnt_idx] & ~i_empty`, combinational.
  - Each cycle with `o_ren`=1 increments `burst_cnt`.
- Leave READ for IDLE at the end of the cycle in which any of these holds:
  - `i_req[gnt_idx]`=0;
  - `i_empty`=1;
  - `o_ren`=1 and `burst_cnt` = MAX_BURST-1, i.e. the MAX_BURST-th read.
- On every exit from READ, `last_idx` takes `gnt_idx`. The next arbitration therefore starts after the requester that was just served.
- In READ, a cycle with `i_empty`=1 and `i_req[gnt_idx]`=1 issues no read. The grant is released and is not held waiting.
- `o_gnt` is the decoded `gnt_idx` when state is READ, else 0. `o_busy` equals (state == READ).
- The rvalid pipeline shifts every cycle:
  - stage 0 input = {`o_ren`, `gnt_idx`};
  - `o_rvalid` is the one-hot decode of the last stage, gated by its valid bit.
- Requester changes on `i_req` for non-granted indices have no effect during READ.
- Reset values, asserted asynchronously:
  - state IDLE;
  - `gnt_idx` 0;
  - `last_idx` = NUM_REQ-1, so requester 0 has first priority after reset;
  - `burst_cnt` 0;
  - rvalid pipeline cleared;
  - outputs `o_ren`, `o_gnt`, `o_rvalid`, `o_busy` all 0.
- Reset mid-burst discards in-flight rvalid strobes; reads already issued to the FIFO are lost by design.

## Timing
- Request to first `o_ren`: 1 cycle. The IDLE arbitration cycle is a mandatory bubble.
- Back-to-back grants: at least one IDLE cycle between grants, so sustained throughput for N competing requesters with full bursts is MAX_BURST/(MAX_BURST+1).
- `o_rvalid[k]` asserts exactly `RD_LAT` cycles after the `o_ren` it corresponds to, one strobe per read.
- `o_ren` has a combinational path from `i_empty` and `i_req`. Every other output is registered or decoded from registers.

## Structure
- Package `fifo_ctrl_pkg`:
  - state encoding constants `ST_IDLE` and `ST_READ`;
  - parameter range-check constants.
  - The package is shared with the other FIFO control blocks.
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: request vector and start pointer.
  - Outputs: a found flag and the selected index.
  - It is parameterised by `NUM_REQ` and is reusable elsewhere.
- The top level holds the FSM, the burst counter, and the rvalid shift pipeline.

## Test plan
- Reset, then `i_req`=4'b0001 with `i_empty`=0 for 20 cycles → `o_ren` pulses 8 cycles, 1 idle, repeats; `o_rvalid`=4'b0001 lags `o_ren` by 1 cycle.
- `i_req`=4'b1111 held, FIFO never empty → grant order 0,1,2,3,0, with 8 reads each and 1 bubble between grants.
- Requester 2 granted; `i_empty` rises after 3 reads → the grant is dropped the same cycle, `o_ren` stays 0 while empty, and on refill the next grant goes to requester 3 if it is requesting.
- Requester 1 deasserts `i_req` after 2 reads → exactly 2 `o_ren` pulses and 2 `o_rvalid[1]` strobes; `last_idx`=1.
- Asynchronous `i_rest` pulse mid-burst with `RD_LAT`=3 → all outputs go to 0 immediately with no later `o_rvalid`; after reset, requester 0 wins if requesting.
- `MAX_BURST`=1, `NUM_REQ`=2, both requesting → `o_ren` alternates 1,0,1,0 with grants 0,1,0,1.
